wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back arbiter that sits directly upstream of the register file and drives its WriteEn/Waddr/DataIn write port.
- Merges single-cycle ALU results with multi-cycle data-memory load returns.
- Keeps a one-entry load scoreboard and raises Stall on read-after-load, write-after-load and write-port collisions.
- All write-port outputs are registered.

Parameters:
W, 8, data path width (matches register file)
A, 2, register address width (2**A registers)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
AluWe  input  1  ALU result valid this cycle
AluWaddr  input  A  ALU destination register
AluData  input  W  ALU result
LoadIssue  input  1  load issued this cycle; destination recorded
LoadWaddr  input  A  load destination register
MemValid  input  1  load data returning this cycle
MemData  input  W  load data
RaddrA  input  A  source register A of instruction in decode
RaddrB  input  A  source register B of instruction in decode
WriteEn  output  1  register file write enable (registered)
Waddr  output  A  register file write address (registered)
DataIn  output  W  register file write data (registered)
Stall  output  1  combinational; upstream must hold its instruction and inputs
LoadBusy  output  1  registered; 1 while state is not IDLE

Behaviour:
- Reset low forces, asynchronously:
  - state to IDLE, PendValid to 0, HoldValid to 0;
  - WriteEn, Waddr, DataIn and LoadBusy to 0.
- A load in flight is discarded by reset. MemValid arriving after reset is ignored.
- State machine:
  - IDLE: no load pending. An accepted LoadIssue sets PendValid=1 and PendAddr=LoadWaddr, then goes to WAIT. MemValid is ignored.
  - WAIT: load pending. MemValid captures MemData into the output registers, then goes to COMMIT.
  - COMMIT: load write is on the output port. Goes to IDLE at the next edge, and PendValid clears at that edge.
- Only one load may be outstanding. Stall=1 when LoadIssue=1 and the state is not IDLE.
- Stall=1 in any of these cases:
  - PendValid=1 and RaddrA==PendAddr or RaddrB==PendAddr (read-after-load, held until the register file has captured the load);
  - state is WAIT and AluWe=1 and AluWaddr==PendAddr (write-after-write);
  - HoldValid=1 and AluWe=1 (hold buffer occupied).
- In a Stall cycle, AluWe and LoadIssue are not accepted and no internal state is updated from them. MemValid and hold-buffer draining still proceed.
- Write-port arbitration at each edge, highest priority first:
  1. MemValid in WAIT: output {1, PendAddr, MemData}.
  2. HoldValid: output the held ALU write; HoldValid then clears.
  3. Accepted AluWe: output {1, AluWaddr, AluData}.
  4. None of the above: WriteEn=0. Waddr and DataIn keep their previous values.
- If MemValid in WAIT and an accepted AluWe occur in the same cycle, the ALU write goes into the hold buffer (HoldValid=1). The buffer drains in the following COMMIT cycle.
- Latency: a write accepted before edge k appears on WriteEn in the cycle after edge k, and the register file captures it at edge k+1.
- A held ALU write therefore incurs 1 extra cycle.
- If LoadIssue and AluWe are accepted in the same IDLE cycle, both are taken: the ALU write goes out and the load is recorded.
- LoadWaddr equal to AluWaddr in that same IDLE cycle is legal. The load commits later, so the load value wins.
- No arithmetic is performed. Data passes through unmodified at width W.

Test Plan:
- Reset mid-load: issue load to r2, pull Reset low during WAIT, release, pulse MemValid with 0x55. Required: WriteEn stays 0, LoadBusy=0, Stall=0.
- ALU write: AluWe=1, r1, 0x3C for one cycle. Required: next cycle WriteEn=1, Waddr=1, DataIn=0x3C; the cycle after, WriteEn=0.
- Load-use hazard: LoadIssue to r3; next cycle RaddrA=3; MemValid with 0xA5 three cycles later. Required: Stall=1 from the cycle after issue through the COMMIT cycle; Stall=0 once r3=0xA5 is in the register file.
- Collision: in WAIT (load to r2), MemValid with 0x11 and AluWe r0 with 0x22 in the same cycle. Required: next cycle write {r2,0x11}, then {r0,0x22}; HoldValid clears.
- Hold full: in COMMIT with HoldValid=1, assert AluWe r1 with 0x77. Required: Stall=1 and the ALU write is not accepted; it is accepted the following cycle and written as {r1,0x77} one cycle later.
- Second load: LoadIssue while in WAIT. Required: Stall=1 and PendAddr unchanged.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Write-back arbiter in front of the register file write port.
//            Merges single-cycle ALU results with multi-cycle load returns,
//            tracks one outstanding load and raises Stall on hazards.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int W = 8,
    parameter int A = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluWe,
    input  logic [A-1:0] AluWaddr,
    input  logic [W-1:0] AluData,
    input  logic         LoadIssue,
    input  logic [A-1:0] LoadWaddr,
    input  logic         MemValid,
    input  logic [W-1:0] MemData,
    input  logic [A-1:0] RaddrA,
    input  logic [A-1:0] RaddrB,
    output logic         WriteEn,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         Stall,
    output logic         LoadBusy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_pend_valid;
    logic [A-1:0]   r_pend_addr;
    logic           r_hold_valid;
    logic [A-1:0]   r_hold_addr;
    logic [W-1:0]   r_hold_data;
    logic           r_we;
    logic [A-1:0]   r_waddr;
    logic [W-1:0]   r_data;
    logic           r_load_busy;

    state_t         w_state_nxt;
    logic           w_pend_valid_nxt;
    logic [A-1:0]   w_pend_addr_nxt;
    logic           w_hold_valid_nxt;
    logic [A-1:0]   w_hold_addr_nxt;
    logic [W-1:0]   w_hold_data_nxt;
    logic           w_we_nxt;
    logic [A-1:0]   w_waddr_nxt;
    logic [W-1:0]   w_data_nxt;
    logic           w_stall;
    logic           w_mem_wr;
    logic           w_alu_acc;
    logic           w_load_acc;

    // Hazard detection, next-state and write-port arbitration
    always_comb begin
        w_state_nxt      = r_state;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_addr_nxt  = r_pend_addr;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_addr_nxt  = r_hold_addr;
        w_hold_data_nxt  = r_hold_data;
        w_we_nxt         = 1'b0;
        w_waddr_nxt      = r_waddr;
        w_data_nxt       = r_data;

        w_mem_wr = (r_state == S_WAIT) && MemValid;

        // Read-after-load is held until the COMMIT->IDLE edge, which is the
        // edge at which the register file captures the load value.
        w_stall = (LoadIssue && (r_state != S_IDLE))
               || (r_pend_valid && ((RaddrA == r_pend_addr) || (RaddrB == r_pend_addr)))
               || ((r_state == S_WAIT) && AluWe && (AluWaddr == r_pend_addr))
               || (r_hold_valid && AluWe);

        w_alu_acc  = AluWe && !w_stall;
        w_load_acc = LoadIssue && !w_stall && (r_state == S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_load_acc) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_addr_nxt  = LoadWaddr;
                    w_state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_mem_wr) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_pend_valid_nxt = 1'b0;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_pend_valid_nxt = 1'b0;
                w_state_nxt      = S_IDLE;
            end
        endcase

        // Load return has the port; a coincident ALU write is parked and
        // drains during the following COMMIT cycle.
        if (w_mem_wr) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_pend_addr;
            w_data_nxt  = MemData;
            if (w_alu_acc) begin
                w_hold_valid_nxt = 1'b1;
                w_hold_addr_nxt  = AluWaddr;
                w_hold_data_nxt  = AluData;
            end
        end else if (r_hold_valid) begin
            w_we_nxt         = 1'b1;
            w_waddr_nxt      = r_hold_addr;
            w_data_nxt       = r_hold_data;
            w_hold_valid_nxt = 1'b0;
        end else if (w_alu_acc) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = AluWaddr;
            w_data_nxt  = AluData;
        end
    end

    // State, scoreboard, hold buffer and registered write port
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_data       <= '0;
            r_load_busy  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_hold_addr  <= w_hold_addr_nxt;
            r_hold_data  <= w_hold_data_nxt;
            r_we         <= w_we_nxt;
            r_waddr      <= w_waddr_nxt;
            r_data       <= w_data_nxt;
            r_load_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign WriteEn  = r_we;
    assign Waddr    = r_waddr;
    assign DataIn   = r_data;
    assign Stall    = w_stall;
    assign LoadBusy = r_load_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter. Expected register
//            file writes are queued with the cycle they must appear in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int W = 8;
    localparam int A = 2;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         AluWe;
    logic [A-1:0] AluWaddr;
    logic [W-1:0] AluData;
    logic         LoadIssue;
    logic [A-1:0] LoadWaddr;
    logic         MemValid;
    logic [W-1:0] MemData;
    logic [A-1:0] RaddrA;
    logic [A-1:0] RaddrB;
    logic         WriteEn;
    logic [A-1:0] Waddr;
    logic [W-1:0] DataIn;
    logic         Stall;
    logic         LoadBusy;

    typedef struct {
        int           cyc;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    wb_arbiter #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluWe(AluWe), .AluWaddr(AluWaddr), .AluData(AluData),
        .LoadIssue(LoadIssue), .LoadWaddr(LoadWaddr),
        .MemValid(MemValid), .MemData(MemData),
        .RaddrA(RaddrA), .RaddrB(RaddrB),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Stall(Stall), .LoadBusy(LoadBusy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Write the expected write into the cycle after the current edge count
    task automatic push_wr(input int dly, input logic [A-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.cyc  = cyc + dly;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare the write port against the scoreboard
    task automatic tick();
        wr_t e;
        @(posedge Clk);
        cyc++;
        #1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("wr_en",   {31'd0, WriteEn}, 32'd1);
            check("wr_addr", {30'd0, Waddr},   {30'd0, e.addr});
            check("wr_data", {24'd0, DataIn},  {24'd0, e.data});
        end else begin
            check("wr_idle", {31'd0, WriteEn}, 32'd0);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, Stall}, {31'd0, exp});
    endtask

    initial begin
        Reset = 1'b0; AluWe = 1'b0; AluWaddr = '0; AluData = '0;
        LoadIssue = 1'b0; LoadWaddr = '0; MemValid = 1'b0; MemData = '0;
        RaddrA = '0; RaddrB = '0;

        // Reset state
        tick(); tick();
        check("rst_waddr", {30'd0, Waddr}, 32'd0);
        check("rst_data",  {24'd0, DataIn}, 32'd0);
        check("rst_busy",  {31'd0, LoadBusy}, 32'd0);
        chk_stall("rst_stall", 1'b0);
        Reset = 1'b1;
        tick();

        // Reset mid-load: load in flight is discarded, late MemValid ignored
        LoadIssue = 1'b1; LoadWaddr = 2'd2;
        chk_stall("rml_issue_stall", 1'b0);
        tick();
        LoadIssue = 1'b0;
        check("rml_busy_wait", {31'd0, LoadBusy}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("rml_busy_rst", {31'd0, LoadBusy}, 32'd0);
        check("rml_we_rst",   {31'd0, WriteEn},  32'd0);
        check("rml_stall_rst", {31'd0, Stall},   32'd0);
        Reset = 1'b1;
        tick();
        MemValid = 1'b1; MemData = 8'h55;
        chk_stall("rml_mem_stall", 1'b0);
        tick();
        MemValid = 1'b0;
        tick();
        check("rml_busy_end", {31'd0, LoadBusy}, 32'd0);

        // Plain ALU write
        AluWe = 1'b1; AluWaddr = 2'd1; AluData = 8'h3C;
        chk_stall("alu_stall", 1'b0);
        push_wr(1, 2'd1, 8'h3C);
        tick();
        AluWe = 1'b0;
        tick();

        // Load-use hazard on r3
        LoadIssue = 1'b1; LoadWaddr = 2'd3;
        chk_stall("lu_issue", 1'b0);
        tick();
        LoadIssue = 1'b0; RaddrA = 2'd3;
        chk_stall("lu_wait1", 1'b1);
        check("lu_busy", {31'd0, LoadBusy}, 32'd1);
        tick();
        RaddrA = 2'd0; RaddrB = 2'd3;
        chk_stall("lu_wait2_b", 1'b1);
        RaddrA = 2'd3; RaddrB = 2'd0;
        tick();
        MemValid = 1'b1; MemData = 8'hA5;
        chk_stall("lu_mem", 1'b1);
        push_wr(1, 2'd3, 8'hA5);
        tick();
        MemValid = 1'b0;
        chk_stall("lu_commit", 1'b1);
        tick();
        chk_stall("lu_done", 1'b0);
        check("lu_busy_end", {31'd0, LoadBusy}, 32'd0);
        RaddrA = 2'd0;

        // Collision: load return and ALU write in the same WAIT cycle
        LoadIssue = 1'b1; LoadWaddr = 2'd2;
        tick();
        LoadIssue = 1'b0;
        MemValid = 1'b1; MemData = 8'h11;
        AluWe = 1'b1; AluWaddr = 2'd0; AluData = 8'h22;
        chk_stall("col_stall", 1'b0);
        push_wr(1, 2'd2, 8'h11);
        push_wr(2, 2'd0, 8'h22);
        tick();
        MemValid = 1'b0; AluWe = 1'b0;
        tick();
        tick();

        // Hold buffer full in COMMIT stalls a new ALU write
        LoadIssue = 1'b1; LoadWaddr = 2'd2;
        tick();
        LoadIssue = 1'b0;
        MemValid = 1'b1; MemData = 8'h44;
        AluWe = 1'b1; AluWaddr = 2'd0; AluData = 8'h22;
        push_wr(1, 2'd2, 8'h44);
        push_wr(2, 2'd0, 8'h22);
        tick();
        MemValid = 1'b0;
        AluWaddr = 2'd1; AluData = 8'h77;
        chk_stall("hold_stall", 1'b1);
        tick();
        chk_stall("hold_accept", 1'b0);
        push_wr(1, 2'd1, 8'h77);
        tick();
        AluWe = 1'b0;
        tick();

        // Second load while one is outstanding
        LoadIssue = 1'b1; LoadWaddr = 2'd1;
        tick();
        LoadWaddr = 2'd2;
        chk_stall("ld2_stall", 1'b1);
        tick();
        LoadIssue = 1'b0;
        RaddrA = 2'd2;
        chk_stall("ld2_pend_not2", 1'b0);
        RaddrA = 2'd1;
        chk_stall("ld2_pend_is1", 1'b1);
        RaddrA = 2'd0;
        MemValid = 1'b1; MemData = 8'h99;
        push_wr(1, 2'd1, 8'h99);
        tick();
        MemValid = 1'b0;
        tick();
        tick();

        // Same-cycle load+ALU in IDLE, then write-after-write stall in WAIT
        LoadIssue = 1'b1; LoadWaddr = 2'd2;
        AluWe = 1'b1; AluWaddr = 2'd2; AluData = 8'h10;
        chk_stall("both_stall", 1'b0);
        push_wr(1, 2'd2, 8'h10);
        tick();
        LoadIssue = 1'b0;
        AluWaddr = 2'd2; AluData = 8'h20;
        chk_stall("waw_stall", 1'b1);
        AluWaddr = 2'd1; AluData = 8'h30;
        chk_stall("waw_other", 1'b0);
        push_wr(1, 2'd1, 8'h30);
        tick();
        AluWe = 1'b0;
        MemValid = 1'b1; MemData = 8'hBB;
        push_wr(1, 2'd2, 8'hBB);
        tick();
        MemValid = 1'b0;
        tick();
        tick();
        check("busy_final", {31'd0, LoadBusy}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
